// File: rtl/write_mem_ring_pkg.sv
// Shared types and constants for the write_mem_ring record writer.
`timescale 1ns/1ps
package write_mem_ring_pkg;

    typedef enum logic [5:0] {
        INIT_ST      = 6'b000001,
        WRITE_ST     = 6'b000010,
        MEMW_ST      = 6'b000100,
        TTAGW_ST     = 6'b001000,
        DROP_ST      = 6'b010000,
        WRITE_ACK_ST = 6'b100000
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RING    = 1'b1;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/write_mem_ring_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
`timescale 1ns/1ps
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/write_mem_ring.sv
// Record writer: NSAMP samples plus a time-tag word per 4-phase request, one-shot or ring.
// Optional drop counter enabled by defining WRITE_MEM_RING_DROP_CNT_EN.
`timescale 1ns/1ps
module write_mem_ring
    import write_mem_ring_pkg::*;
#(
    parameter int N  = 4,
    parameter int B  = 8,
    parameter int L  = 4,
    parameter int TW = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [L*B-1:0]        din,
    input  logic [TW-1:0]         ttag,
    input  logic                  write,
    output logic                  write_ack,
    output logic                  mem_we,
    output logic [N-1:0]          mem_addr,
    output logic [L*B-1:0]        mem_di,
    input  logic [N-1:0]          NSAMP_REG,
    input  logic                  MODE_REG,
    output logic [N:0]            nrec,
    output logic                  wrapped,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int W = L * B;
    localparam logic [N:0] DEPTH = {1'b1, {N{1'b0}}};

    generate
        if (TW < 1 || TW > W) begin : g_tw_bad
            $error("write_mem_ring: TW must satisfy 1 <= TW <= L*B");
        end
    endgenerate

    state_t       state_q, state_d;
    logic [N:0]   addr_q, addr_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] nsamp_q, nsamp_d;
    logic         mode_q, mode_d;
    logic         wrapped_q, wrapped_d;

    logic         stat_clr;
    logic         nrec_inc;
    logic         drop_inc;
    logic [N:0]   len;
    logic [N:0]   free;
    logic [N:0]   addr_inc;
    logic [W-1:0] ttag_ext;

    always_comb begin
        ttag_ext          = '0;
        ttag_ext[TW-1:0]  = ttag;
    end

    // Ring mode keeps the top address bit clear so addr simply wraps at 2^N.
    always_comb begin
        len  = {1'b0, nsamp_q} + (N+1)'(1);
        free = DEPTH - addr_q;
        if (mode_q == MODE_RING) begin
            addr_inc = {1'b0, addr_q[N-1:0] + N'(1)};
        end else begin
            addr_inc = addr_q + (N+1)'(1);
        end
    end

    always_comb begin
        mem_we    = (state_q == MEMW_ST) || (state_q == TTAGW_ST);
        write_ack = (state_q == WRITE_ACK_ST);
        mem_addr  = addr_q[N-1:0];
        mem_di    = '0;
        if (state_q == MEMW_ST) begin
            mem_di = din;
        end else if (state_q == TTAGW_ST) begin
            mem_di = ttag_ext;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        nsamp_d   = nsamp_q;
        mode_d    = mode_q;
        wrapped_d = wrapped_q;
        stat_clr  = 1'b0;
        nrec_inc  = 1'b0;
        drop_inc  = 1'b0;

        unique case (state_q)
            INIT_ST: begin
                addr_d  = '0;
                cnt_d   = '0;
                nsamp_d = NSAMP_REG;
                mode_d  = MODE_REG;
                if (start) begin
                    state_d   = WRITE_ST;
                    stat_clr  = 1'b1;
                    wrapped_d = 1'b0;
                end
            end
            WRITE_ST: begin
                cnt_d = '0;
                if (!start) begin
                    state_d = INIT_ST;
                end else if (write) begin
                    if ((mode_q == MODE_ONESHOT) && (len > free)) begin
                        state_d = DROP_ST;
                    end else if (nsamp_q == '0) begin
                        state_d = TTAGW_ST;
                    end else begin
                        state_d = MEMW_ST;
                    end
                end
            end
            MEMW_ST: begin
                addr_d = addr_inc;
                cnt_d  = cnt_q + N'(1);
                if (cnt_q == nsamp_q - N'(1)) begin
                    state_d = TTAGW_ST;
                end
            end
            TTAGW_ST: begin
                addr_d   = addr_inc;
                nrec_inc = 1'b1;
                state_d  = WRITE_ACK_ST;
            end
            DROP_ST: begin
                drop_inc = 1'b1;
                state_d  = WRITE_ACK_ST;
            end
            WRITE_ACK_ST: begin
                if (!write) begin
                    state_d = WRITE_ST;
                end
            end
            default: begin
                state_d = INIT_ST;
            end
        endcase

        // Writing the last location in ring mode means the next write overwrites address 0.
        if (mem_we && (mode_q == MODE_RING) && (addr_q[N-1:0] == {N{1'b1}})) begin
            wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= INIT_ST;
            addr_q    <= '0;
            cnt_q     <= '0;
            nsamp_q   <= '0;
            mode_q    <= MODE_ONESHOT;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            nsamp_q   <= nsamp_d;
            mode_q    <= mode_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign wrapped = wrapped_q;

    sat_cnt #(.W(N + 1)) u_nrec_cnt (
        .clk (aclk),
        .rst (areset),
        .clr (stat_clr),
        .inc (nrec_inc),
        .cnt (nrec)
    );

`ifdef WRITE_MEM_RING_DROP_CNT_EN
    sat_cnt #(.W(DROP_CNT_W)) u_drop_cnt (
        .clk (aclk),
        .rst (areset),
        .clr (stat_clr),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );
`else
    assign drop_cnt = '0;
    logic unused_drop;
    assign unused_drop = drop_inc;
`endif

endmodule
